stepper_axis_ctrl: RTL and testbench



---
 rtl/stepper_pkg.sv | 25 ++
 rtl/stepper_ramp_gen.sv | 70 +++++++
 rtl/stepper_axis_ctrl.sv | 150 +++++++++++++++
 tb/tb_stepper_axis_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types for the stepper axis controller: FSM states, command op codes
// and the full-step two-phase coil table.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_HOLDING  = 2'd1,
        ST_MOVING   = 2'd2
    } state_t;

    localparam logic [1:0] OP_MOVE    = 2'b00;
    localparam logic [1:0] OP_HOLD    = 2'b01;
    localparam logic [1:0] OP_RELEASE = 2'b10;
    localparam logic [1:0] OP_ZERO    = 2'b11;

    // {A, B} coil polarity for each phase index
    localparam logic [1:0] PHASE_AB [4] = '{2'b11, 2'b01, 2'b00, 2'b10};

    function automatic logic [3:0] phase_pins(input logic [1:0] idx);
        logic [1:0] ab;
        ab = PHASE_AB[idx];
        return {ab[1], ~ab[1], ab[0], ~ab[0]};
    endfunction

endpackage

// File: rtl/stepper_ramp_gen.sv
// Step timing for one move: owns the step period, the ramp depth counter and
// the step counter, and flags the cycle on which a step edge happens.
module stepper_ramp_gen #(
    parameter int POS_W      = 21,
    parameter int PER_W      = 22,
    parameter int MIN_PERIOD = 526316,
    parameter int MAX_PERIOD = 2000000,
    parameter int ACCEL_STEP = 20000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             is_last,
    input  logic [POS_W-1:0] rem,
    output logic             step
);

    localparam logic [PER_W-1:0] MAX_V = PER_W'(MAX_PERIOD);
    localparam logic [PER_W-1:0] MIN_V = PER_W'(MIN_PERIOD);
    localparam logic [PER_W-1:0] ACC_V = PER_W'(ACCEL_STEP);
    localparam logic [PER_W:0]   MAX_W = (PER_W+1)'(MAX_PERIOD);
    localparam logic [PER_W-1:0] ONE_P = PER_W'(1);
    localparam logic [POS_W-1:0] ONE_R = POS_W'(1);

    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] ramp_q, ramp_d;
    logic [PER_W:0]   per_up;

    always_comb begin
        step     = run && (cnt_q == period_q - ONE_P);
        per_up   = {1'b0, period_q} + {1'b0, ACC_V};
        period_d = period_q;
        cnt_d    = cnt_q;
        ramp_d   = ramp_q;
        if (start) begin
            period_d = MAX_V;
            cnt_d    = '0;
            ramp_d   = '0;
        end else if (step) begin
            cnt_d = '0;
            // Decelerate once the remaining distance fits inside the ramp built so far
            if (!is_last) begin
                if (rem <= ramp_q) begin
                    period_d = (per_up > MAX_W) ? MAX_V : per_up[PER_W-1:0];
                    ramp_d   = ramp_q - ONE_R;
                end else if (period_q > MIN_V) begin
                    period_d = (period_q > MIN_V + ACC_V) ? period_q - ACC_V : MIN_V;
                    ramp_d   = ramp_q + ONE_R;
                end
            end
        end else if (run) begin
            cnt_d = cnt_q + ONE_P;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= MAX_V;
            cnt_q    <= '0;
            ramp_q   <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            ramp_q   <= ramp_d;
        end
    end

endmodule

// File: rtl/stepper_axis_ctrl.sv
// Single-axis bipolar stepper controller: absolute moves with a linear period ramp.
// Define STEPPER_IDLE_RELEASE_EN to de-energise the coils after IDLE_CYCLES idle in HOLDING.
module stepper_axis_ctrl
    import stepper_pkg::*;
#(
    parameter int POS_W       = 21,
    parameter int PER_W       = 22,
    parameter int MIN_PERIOD  = 526316,
    parameter int MAX_PERIOD  = 2000000,
    parameter int ACCEL_STEP  = 20000,
    parameter int IDLE_CYCLES = 100000000
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [POS_W-1:0] cmd_target,
    input  logic             halt,
    output logic [5:0]       JA,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done
);

    if (MIN_PERIOD < 1 || MAX_PERIOD < MIN_PERIOD || IDLE_CYCLES < 1 ||
        MAX_PERIOD >= 2**PER_W) begin : g_bad_params
        $error("stepper_axis_ctrl: inconsistent timing parameters");
    end

    localparam logic [POS_W-1:0] ONE_POS = POS_W'(1);

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d, target_q, target_d, new_pos, rem;
    logic [POS_W:0]   diff;
    logic [1:0]       phase_q, phase_d;
    logic             finish_q, finish_d, done_q, done_d, busy_q, busy_d;
    logic [5:0]       ja_q, ja_d;
    logic             accept, fwd, is_last, run, start, step, en;

`ifdef STEPPER_IDLE_RELEASE_EN
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    assign cmd_ready = (state_q != ST_MOVING) && !halt;
    assign accept    = cmd_valid && cmd_ready;
    assign fwd       = $signed(target_q) > $signed(pos_q);
    assign new_pos   = fwd ? pos_q + ONE_POS : pos_q - ONE_POS;
    assign diff      = {target_q[POS_W-1], target_q} - {new_pos[POS_W-1], new_pos};
    assign rem       = diff[POS_W] ? POS_W'(-diff) : POS_W'(diff);
    assign is_last   = (rem == '0);
    // The cycle between the last step and HOLDING must not count toward a new step
    assign run       = (state_q == ST_MOVING) && !finish_q && !halt;
    assign start     = accept && (cmd_op == OP_MOVE) && (cmd_target != pos_q);

    stepper_ramp_gen #(
        .POS_W(POS_W), .PER_W(PER_W), .MIN_PERIOD(MIN_PERIOD),
        .MAX_PERIOD(MAX_PERIOD), .ACCEL_STEP(ACCEL_STEP)
    ) u_ramp (
        .clk(CLK100MHZ), .reset(reset), .start(start), .run(run),
        .is_last(is_last), .rem(rem), .step(step)
    );

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        target_d = target_q;
        phase_d  = phase_q;
        finish_d = finish_q;
        done_d   = 1'b0;
`ifdef STEPPER_IDLE_RELEASE_EN
        idle_d   = '0;
`endif
        if (halt) begin
            state_d  = ST_RELEASED;
            finish_d = 1'b0;
        end else if (state_q == ST_MOVING) begin
            if (finish_q) begin
                state_d  = ST_HOLDING;
                finish_d = 1'b0;
                done_d   = 1'b1;
            end else if (step) begin
                pos_d    = new_pos;
                phase_d  = fwd ? phase_q + 2'd1 : phase_q - 2'd1;
                finish_d = is_last;
            end
        end else if (accept) begin
            case (cmd_op)
                OP_MOVE: begin
                    target_d = cmd_target;
                    if (cmd_target != pos_q) begin
                        state_d = ST_MOVING;
                    end else begin
                        state_d = ST_HOLDING;
                        done_d  = 1'b1;
                    end
                end
                OP_HOLD:    state_d = ST_HOLDING;
                OP_RELEASE: state_d = ST_RELEASED;
                default:    pos_d   = '0;
            endcase
        end else if (state_q == ST_HOLDING) begin
`ifdef STEPPER_IDLE_RELEASE_EN
            if (idle_q == IDLE_W'(IDLE_CYCLES - 1)) begin
                state_d = ST_RELEASED;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
`endif
        end
        busy_d = (state_d == ST_MOVING);
        en     = (state_d != ST_RELEASED);
        ja_d   = {en, en, phase_pins(phase_d)};
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q  <= ST_RELEASED;
            pos_q    <= '0;
            target_q <= '0;
            phase_q  <= 2'd0;
            finish_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ja_q     <= 6'b000000;
`ifdef STEPPER_IDLE_RELEASE_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            phase_q  <= phase_d;
            finish_q <= finish_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ja_q     <= ja_d;
`ifdef STEPPER_IDLE_RELEASE_EN
            idle_q   <= idle_d;
`endif
        end
    end

    assign JA       = ja_q;
    assign position = pos_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// Self-checking bench for stepper_axis_ctrl with a step-schedule reference model.
module tb_stepper_axis_ctrl;

    localparam int POS_W = 21;
    localparam int PER_W = 22;
    localparam int MINP  = 4;
    localparam int MAXP  = 8;
    localparam int ACC   = 2;
    localparam int IDLE  = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [POS_W-1:0] cmd_target = '0;
    logic             halt = 1'b0;
    logic [5:0]       JA;
    logic [POS_W-1:0] position;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    stepper_axis_ctrl #(
        .POS_W(POS_W), .PER_W(PER_W), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP),
        .ACCEL_STEP(ACC), .IDLE_CYCLES(IDLE)
    ) dut (
        .CLK100MHZ(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_target(cmd_target), .halt(halt), .JA(JA),
        .position(position), .busy(busy), .done(done)
    );

    // model: 0 released, 1 holding, 2 moving
    int m_state = 0, m_pos = 0, m_tgt = 0, m_phase = 0;
    int m_period = MAXP, m_ramp = 0, m_wait = 0, m_idle = 0;
    bit m_fin = 0, m_done = 0, m_live = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] coil_pins(input int ph);
        logic a, b;
        a = (ph == 0) || (ph == 3);
        b = (ph < 2);
        return {a, ~a, b, ~b};
    endfunction

    function automatic logic [5:0] exp_ja();
        logic en;
        en = (m_state != 0);
        return m_live ? {en, en, coil_pins(m_phase)} : 6'b000000;
    endfunction

    task automatic model_edge();
        bit acc;
        int dir, rem, tgt;
        if (reset) begin
            m_state = 0; m_pos = 0; m_phase = 0; m_fin = 0; m_done = 0;
            m_live = 0; m_idle = 0; m_tgt = 0;
            return;
        end
        m_live = 1;
        m_done = 0;
        acc = cmd_valid && (m_state != 2) && !halt;
        tgt = int'($signed(cmd_target));
        if (halt) begin
            m_state = 0; m_fin = 0; m_idle = 0;
        end else if (m_state == 2) begin
            if (m_fin) begin
                m_state = 1; m_done = 1; m_fin = 0; m_idle = 0;
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    dir = (m_tgt > m_pos) ? 1 : -1;
                    m_pos += dir;
                    m_phase = (m_phase + dir + 4) % 4;
                    rem = (m_tgt > m_pos) ? m_tgt - m_pos : m_pos - m_tgt;
                    if (rem == 0) m_fin = 1;
                    else if (rem <= m_ramp) begin
                        m_period = (m_period + ACC > MAXP) ? MAXP : m_period + ACC;
                        m_ramp--;
                    end else if (m_period > MINP) begin
                        m_period = (m_period - ACC < MINP) ? MINP : m_period - ACC;
                        m_ramp++;
                    end
                    m_wait = m_period;
                end
            end
        end else if (acc) begin
            m_idle = 0;
            case (cmd_op)
                2'b00: begin
                    if (tgt != m_pos) begin
                        m_state = 2; m_tgt = tgt; m_period = MAXP; m_ramp = 0; m_wait = MAXP;
                    end else begin
                        m_state = 1; m_done = 1;
                    end
                end
                2'b01: m_state = 1;
                2'b10: m_state = 0;
                default: m_pos = 0;
            endcase
        end else if (m_state == 1) begin
`ifdef STEPPER_IDLE_RELEASE_EN
            m_idle++;
            if (m_idle == IDLE) begin
                m_state = 0; m_idle = 0;
            end
`endif
        end else begin
            m_idle = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, (m_state != 2) && !halt});
            chk("ja", {26'b0, JA}, {26'b0, exp_ja()});
            chk("position", 32'($signed(position)), m_pos);
            chk("busy", {31'b0, busy}, {31'b0, m_state == 2});
            chk("done", {31'b0, done}, {31'b0, m_done});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] op, input int tgt);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_target = POS_W'(tgt);
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        chk("done_within_budget", {31'b0, seen}, 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int r, n;
        tick();
        chk_en = 1;
        tick();
        tick();
        chk("rst_ja", {26'b0, JA}, 32'h0);
        chk("rst_pos", 32'($signed(position)), 32'd0);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        tick();

        // MOVE 3 from 0: steps at +8, +14, +22, done at +23
        send(2'b00, 3);
        repeat (7) tick();
        chk("m3_e7_pos", 32'($signed(position)), 32'd0);
        tick();
        chk("m3_e8_pos", 32'($signed(position)), 32'd1);
        repeat (5) tick();
        chk("m3_e13_pos", 32'($signed(position)), 32'd1);
        tick();
        chk("m3_e14_pos", 32'($signed(position)), 32'd2);
        repeat (7) tick();
        chk("m3_e21_pos", 32'($signed(position)), 32'd2);
        tick();
        chk("m3_e22_pos", 32'($signed(position)), 32'd3);
        chk("m3_e22_done", {31'b0, done}, 32'd0);
        chk("m3_e22_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("m3_e23_done", {31'b0, done}, 32'd1);
        chk("m3_e23_busy", {31'b0, busy}, 32'd0);
        chk("m3_e23_en", {30'b0, JA[5:4]}, 32'd3);
        chk("model_pos3", m_pos, 32'd3);
        tick();
        chk("m3_e24_done", {31'b0, done}, 32'd0);

        // MOVE -2 from 0 after reset: phase 0 -> 3 -> 2
        pulse_reset();
        send(2'b00, -2);
        repeat (7) tick();
        chk("mn2_e7_ja", {26'b0, JA}, {26'b0, 6'b111010});
        tick();
        chk("mn2_e8_ja", {26'b0, JA}, {26'b0, 6'b111001});
        chk("mn2_e8_pos", 32'($signed(position)), -32'sd1);
        repeat (6) tick();
        chk("mn2_e14_ja", {26'b0, JA}, {26'b0, 6'b110101});
        chk("mn2_e14_pos", 32'($signed(position)), -32'sd2);
        tick();
        chk("mn2_e15_done", {31'b0, done}, 32'd1);
        chk("model_phase2", m_phase, 32'd2);

        // halt at cycle 10 of a 20-step move
        send(2'b11, 0);
        send(2'b00, 20);
        repeat (9) tick();
        halt = 1'b1;
        tick();
        chk("halt_en", {30'b0, JA[5:4]}, 32'd0);
        chk("halt_pos", 32'($signed(position)), 32'd1);
        cmd_valid = 1'b1;
        cmd_op = 2'b00;
        cmd_target = POS_W'(7);
        repeat (3) begin
            tick();
            chk("halt_frozen_pos", 32'($signed(position)), 32'd1);
            chk("halt_no_done", {31'b0, done}, 32'd0);
            chk("halt_not_ready", {31'b0, cmd_ready}, 32'd0);
        end
        halt = 1'b0;
        cmd_valid = 1'b0;
        tick();
        send(2'b00, 20);
        repeat (7) tick();
        chk("resume_e7_pos", 32'($signed(position)), 32'd1);
        tick();
        chk("resume_e8_pos", 32'($signed(position)), 32'd2);
        wait_done(2000);
        chk("resume_final_pos", 32'($signed(position)), 32'd20);

        // back to 5, ZERO while holding, then MOVE 0 completes without a step
        send(2'b00, 5);
        wait_done(2000);
        chk("back_pos5", 32'($signed(position)), 32'd5);
        send(2'b11, 0);
        chk("zero_pos", 32'($signed(position)), 32'd0);
        chk("zero_en", {30'b0, JA[5:4]}, 32'd3);
        send(2'b00, 0);
        chk("move0_done", {31'b0, done}, 32'd1);
        chk("move0_busy", {31'b0, busy}, 32'd0);
        chk("move0_pos", 32'($signed(position)), 32'd0);
`ifdef STEPPER_IDLE_RELEASE_EN
        repeat (15) tick();
        chk("idle_en_kept", {30'b0, JA[5:4]}, 32'd3);
        tick();
        chk("idle_en_drop", {30'b0, JA[5:4]}, 32'd0);
`else
        tick();
        chk("move0_done_clr", {31'b0, done}, 32'd0);
`endif

        // randomized commands, halts and resets against the model
        repeat (150) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                pulse_reset();
            end else if (r < 10) begin
                halt = 1'b1;
                cmd_valid = $urandom_range(0, 1);
                n = $urandom_range(1, 4);
                repeat (n) tick();
                halt = 1'b0;
                cmd_valid = 1'b0;
            end else if (r < 65) begin
                send(2'b00, int'($urandom_range(0, 60)) - 30);
            end else begin
                send(2'($urandom_range(1, 3)), int'($urandom_range(0, 60)) - 30);
            end
            n = $urandom_range(0, 400);
            repeat (n) tick();
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
